// File: rtl/beam_thresh_loader.sv
// Shadow-buffered per-beam threshold loader: scans dirty beams onto the shared bus, then pulses a global update.
// Optional read port for the shadow registers under `define BEAM_THRESH_READBACK_EN.
module beam_thresh_loader #(
  parameter int                      NBEAMS         = 46,
  parameter int                      THRESH_BITS    = 18,
  parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = 18'h3FFFF,
  parameter int                      SETTLE_CYCLES  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [$clog2(NBEAMS)-1:0]  wr_beam_i,
  input  logic [THRESH_BITS-1:0]     wr_thresh_i,
  input  logic                       commit_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [THRESH_BITS-1:0]     thresh_o,
  output logic [NBEAMS-1:0]          thresh_ce_o,
`ifdef BEAM_THRESH_READBACK_EN
  input  logic [$clog2(NBEAMS)-1:0]  rd_beam_i,
  output logic [THRESH_BITS-1:0]     rd_thresh_o,
`endif
  output logic                       update_o
);

  localparam int                 IW          = $clog2(NBEAMS);
  localparam logic [IW-1:0]      LAST_BEAM   = IW'(NBEAMS - 1);
  localparam logic [3:0]         SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [NBEAMS-1:0]  ONE_HOT0    = NBEAMS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [3:0]              settle_cnt;
  logic                    pending;
  logic [THRESH_BITS-1:0]  shadow [NBEAMS];
  logic [NBEAMS-1:0]       dirty;
  logic [NBEAMS-1:0]       ce_q;
  logic [THRESH_BITS-1:0]  thresh_q;
  logic                    err_q;

  logic                    start;
  logic                    wr_fire;
  logic                    wr_in_range;
  logic                    load_hit;
  logic [THRESH_BITS-1:0]  load_val;
  logic                    load_dirty;

  assign start       = (state == S_IDLE) && (commit_i || pending);
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_in_range = (wr_beam_i <= LAST_BEAM);

  // A write landing on the same edge that starts the scan must be seen by beam 0's load.
  assign load_hit   = wr_fire && wr_in_range && (wr_beam_i == idx_n);
  assign load_val   = load_hit ? wr_thresh_i : shadow[idx_n];
  assign load_dirty = load_hit || dirty[idx_n];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: begin
        if (commit_i || pending) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      S_LOAD: begin
        if (idx == LAST_BEAM) begin
          state_n = (SETTLE_CYCLES == 0) ? S_UPDATE : S_SETTLE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n = S_UPDATE;
        end
      end
      S_UPDATE: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready_o = (state == S_IDLE) && !rst_i;
    busy_o     = (state == S_LOAD) || (state == S_SETTLE) || (state == S_UPDATE);
    update_o   = (state == S_UPDATE);
    done_o     = (state == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow[b] <= DEFAULT_THRESH;
      end
      dirty    <= '1;
      pending  <= 1'b1;
      ce_q     <= '0;
      thresh_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state != S_IDLE) && commit_i) begin
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end

      if (start) begin
        err_q <= 1'b0;
      end
      if (wr_fire && !wr_in_range) begin
        err_q <= 1'b1;
      end

      if (wr_fire && wr_in_range) begin
        shadow[wr_beam_i] <= wr_thresh_i;
        dirty[wr_beam_i]  <= 1'b1;
      end

      // Clearing the scanned beam's dirty bit must win over a same-edge write to it.
      if (state_n == S_LOAD) begin
        ce_q         <= load_dirty ? (ONE_HOT0 << idx_n) : '0;
        thresh_q     <= load_val;
        dirty[idx_n] <= 1'b0;
      end else begin
        ce_q <= '0;
      end
    end
  end

  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign err_o       = err_q;

`ifdef BEAM_THRESH_READBACK_EN
  logic [THRESH_BITS-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= (rd_beam_i <= LAST_BEAM) ? shadow[rd_beam_i] : '0;
    end
  end

  assign rd_thresh_o = rd_q;
`endif

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader (NBEAMS=46, SETTLE_CYCLES=2).
module tb_beam_thresh_loader;

  localparam int NB = 46;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [5:0]        wr_beam;
  logic [17:0]       wr_thresh;
  logic              commit;
  logic              busy;
  logic              done;
  logic              err;
  logic [17:0]       thresh;
  logic [NB-1:0]     thresh_ce;
  logic              update;
`ifdef BEAM_THRESH_READBACK_EN
  logic [5:0]        rd_beam;
  logic [17:0]       rd_thresh;
`endif

  int tests = 0;
  int fails = 0;
  logic [17:0]   exp_shadow [NB];
  logic [NB-1:0] one_b;
  logic [NB-1:0] all_b;

  always #5 clk = ~clk;

  beam_thresh_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_beam_i   (wr_beam),
    .wr_thresh_i (wr_thresh),
    .commit_i    (commit),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .thresh_o    (thresh),
    .thresh_ce_o (thresh_ce),
`ifdef BEAM_THRESH_READBACK_EN
    .rd_beam_i   (rd_beam),
    .rd_thresh_o (rd_thresh),
`endif
    .update_o    (update)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one full sequence from the IDLE cycle; ends in the DONE cycle.
  task automatic run_seq(input logic [NB-1:0] mask, input bit commit_now,
                         input int commit_at, input string tag);
    logic [NB-1:0] e;
    commit = commit_now;
    tick;
    commit   = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      e = mask[i] ? (one_b << i) : '0;
      chk({tag, "_ce"},       64'(thresh_ce), 64'(e));
      chk({tag, "_thresh"},   64'(thresh),    64'(exp_shadow[i]));
      chk({tag, "_busy"},     64'(busy),      64'd1);
      chk({tag, "_wr_ready"}, 64'(wr_ready),  64'd0);
      chk({tag, "_update"},   64'(update),    64'd0);
      if (i == 0) chk({tag, "_err_clr"}, 64'(err), 64'd0);
      commit = (commit_at >= 0) && (i >= commit_at) && (i < commit_at + 3);
      tick;
    end
    commit = 1'b0;
    chk({tag, "_settle_ce"},     64'(thresh_ce), 64'd0);
    chk({tag, "_settle_thresh"}, 64'(thresh),    64'(exp_shadow[NB-1]));
    chk({tag, "_settle_upd"},    64'(update),    64'd0);
    chk({tag, "_settle_rdy"},    64'(wr_ready),  64'd0);
    tick;
    chk({tag, "_settle2_upd"},   64'(update),    64'd0);
    tick;
    chk({tag, "_update"},        64'(update),    64'd1);
    chk({tag, "_update_ce"},     64'(thresh_ce), 64'd0);
    chk({tag, "_update_done"},   64'(done),      64'd0);
    tick;
    chk({tag, "_done"},          64'(done),      64'd1);
    chk({tag, "_done_busy"},     64'(busy),      64'd0);
    chk({tag, "_done_upd"},      64'(update),    64'd0);
  endtask

  initial begin
    one_b     = NB'(1);
    all_b     = '1;
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_beam   = '0;
    wr_thresh = '0;
    commit    = 1'b0;
`ifdef BEAM_THRESH_READBACK_EN
    rd_beam   = '0;
`endif
    for (int b = 0; b < NB; b++) exp_shadow[b] = 18'h3FFFF;

    tick; tick; tick;
    chk("rst_ce",       64'(thresh_ce), 64'd0);
    chk("rst_thresh",   64'(thresh),    64'd0);
    chk("rst_update",   64'(update),    64'd0);
    chk("rst_done",     64'(done),      64'd0);
    chk("rst_busy",     64'(busy),      64'd0);
    chk("rst_err",      64'(err),       64'd0);
    chk("rst_wr_ready", 64'(wr_ready),  64'd0);
`ifdef BEAM_THRESH_READBACK_EN
    chk("rst_rd",       64'(rd_thresh), 64'd0);
`endif

    rst = 1'b0;
    #1;
    chk("idle_wr_ready", 64'(wr_ready), 64'd1);
    run_seq(all_b, 1'b0, -1, "auto");
    tick;
    chk("auto_idle_done", 64'(done), 64'd0);
    chk("auto_idle_busy", 64'(busy), 64'd0);

    // single dirty beam
    wr_valid = 1'b1; wr_beam = 6'd7; wr_thresh = 18'h01234;
    tick;
    wr_valid = 1'b0;
    exp_shadow[7] = 18'h01234;
    run_seq(one_b << 7, 1'b1, -1, "single");
    tick;

    // write and commit on the same cycle
    wr_valid = 1'b1; wr_beam = 6'd45; wr_thresh = 18'h00ABC;
    exp_shadow[45] = 18'h00ABC;
    run_seq(one_b << 45, 1'b1, -1, "wrcommit");
    tick;

    // three commits during LOAD collapse into one follow-up sequence
    wr_valid = 1'b1; wr_beam = 6'd12; wr_thresh = 18'h2AAAA;
    tick;
    wr_valid = 1'b0;
    exp_shadow[12] = 18'h2AAAA;
    run_seq(one_b << 12, 1'b1, 10, "busy1");
    tick;
    chk("busy_gap_done", 64'(done), 64'd0);
    chk("busy_gap_busy", 64'(busy), 64'd0);
    run_seq('0, 1'b0, -1, "busy2");
    tick;
    chk("no_third_a", 64'(busy), 64'd0);
    tick;
    chk("no_third_b", 64'(busy), 64'd0);
    chk("no_third_ce", 64'(thresh_ce), 64'd0);

    // out-of-range write
    wr_valid = 1'b1; wr_beam = 6'd50; wr_thresh = 18'h11111;
    tick;
    wr_valid = 1'b0;
    chk("bad_err_set", 64'(err), 64'd1);
    tick;
    chk("bad_err_sticky", 64'(err), 64'd1);
    run_seq('0, 1'b1, -1, "badidx");
    tick;
    chk("bad_err_after", 64'(err), 64'd0);

`ifdef BEAM_THRESH_READBACK_EN
    wr_valid = 1'b1; wr_beam = 6'd3; wr_thresh = 18'h00055;
    tick;
    wr_valid = 1'b0;
    rd_beam = 6'd3;
    tick;
    chk("rd_beam3", 64'(rd_thresh), 64'h00055);
    rd_beam = 6'd12;
    tick;
    chk("rd_beam12", 64'(rd_thresh), 64'h2AAAA);
    rd_beam = 6'd50;
    tick;
    chk("rd_oob", 64'(rd_thresh), 64'd0);
`endif

    // reset in the middle of LOAD
    wr_valid = 1'b1; wr_beam = 6'd20; wr_thresh = 18'h0F0F0;
    tick;
    wr_valid = 1'b0;
    commit = 1'b1;
    tick;
    commit = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    chk("mid_ce20",     64'(thresh_ce), 64'(one_b << 20));
    chk("mid_thresh20", 64'(thresh),    64'h0F0F0);
    rst = 1'b1;
    tick;
    chk("abort_ce",       64'(thresh_ce), 64'd0);
    chk("abort_thresh",   64'(thresh),    64'd0);
    chk("abort_busy",     64'(busy),      64'd0);
    chk("abort_update",   64'(update),    64'd0);
    chk("abort_done",     64'(done),      64'd0);
    chk("abort_wr_ready", 64'(wr_ready),  64'd0);
    rst = 1'b0;
    for (int b = 0; b < NB; b++) exp_shadow[b] = 18'h3FFFF;
    run_seq(all_b, 1'b0, -1, "reload");
    tick;
    chk("reload_idle_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
